// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared types and helpers for the data_ram block.
//   access_size_t : request size encoding (byte / half / word / reserved)
//   ram_state_t   : top-level FSM states
//   byte_mask()   : 4-bit lane enable mask for a size and byte offset
package data_ram_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } access_size_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

  // Lane enables for a little-endian access. Offsets are assumed already
  // alignment-checked by the caller; the reserved size enables nothing.
  function automatic logic [3:0] byte_mask(input access_size_t size,
                                           input logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << offset;
      SIZE_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ram_lane_align.sv
// ram_lane_align: combinational lane steering for data_ram.
//   size      in  access size
//   offset    in  byte offset within the word (addr[1:0])
//   sign_ext  in  1 = sign-extend loads, 0 = zero-extend
//   rd_word   in  raw 32-bit word read from storage
//   st_data   in  right-justified store data
//   be        out per-lane write enables
//   wr_word   out store data replicated onto every lane (be picks the lanes)
//   ld_data   out selected lane(s), extended to 32 bits
module ram_lane_align
  import data_ram_pkg::*;
(
  input  access_size_t size,
  input  logic [1:0]   offset,
  input  logic         sign_ext,
  input  logic [31:0]  rd_word,
  input  logic [31:0]  st_data,
  output logic [3:0]   be,
  output logic [31:0]  wr_word,
  output logic [31:0]  ld_data
);

  logic [31:0] shifted;

  // Bring the addressed lane(s) down to bit 0.
  assign shifted = rd_word >> {offset, 3'b000};

  always_comb begin
    be      = byte_mask(size, offset);
    wr_word = st_data;
    ld_data = shifted;
    case (size)
      SIZE_BYTE: begin
        wr_word = {4{st_data[7:0]}};
        ld_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        wr_word = {2{st_data[15:0]}};
        ld_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        // Word accesses are aligned, so shifted == rd_word here.
        wr_word = st_data;
        ld_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/data_ram.sv
// data_ram: byte-addressed little-endian data memory for the load/store path.
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake; a request is accepted on a posedge
//                     where both are 1, inputs are don't-care otherwise
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 reserved
//   req_signed        load extension select (ignored for words)
//   req_addr          byte address
//   req_wdata         right-justified store data
//   resp_valid        one-cycle pulse the cycle after acceptance
//   resp_rdata        extended load data; 0 for stores and errors
//   resp_err          access rejected (qualified by resp_valid)
//   init_busy         clear sweep in progress
// The internal signal 'state' carries the FSM state for external checkers.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DEPTH_WORDS    = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  init_busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // One extra bit so the limit is representable even when it equals 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(DEPTH_WORDS - 1);

  logic [31:0]      mem [DEPTH_WORDS];
  ram_state_t       state;
  logic [IDX_W-1:0] clr_cnt;

  access_size_t     size;
  logic             accept;
  logic             req_err;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       offset;
  logic [3:0]       be;
  logic [31:0]      wr_word;
  logic [31:0]      ld_data;

  assign size     = access_size_t'(req_size);
  assign accept   = req_valid & req_ready;
  assign word_idx = req_addr[IDX_W+1:2];
  assign offset   = req_addr[1:0];

  // Error priority: reserved size, half misalign, word misalign, out of range.
  always_comb begin
    req_err = 1'b0;
    if (size == SIZE_RSVD)
      req_err = 1'b1;
    else if (size == SIZE_HALF && offset[0])
      req_err = 1'b1;
    else if (size == SIZE_WORD && offset != 2'b00)
      req_err = 1'b1;
    else if ({1'b0, req_addr} >= ADDR_LIMIT)
      req_err = 1'b1;
  end

  ram_lane_align u_align (
    .size     (size),
    .offset   (offset),
    .sign_ext (req_signed),
    .rd_word  (mem[word_idx]),
    .st_data  (req_wdata),
    .be       (be),
    .wr_word  (wr_word),
    .ld_data  (ld_data)
  );

  // Storage: the sweep owns the array during CLEAR; otherwise accepted,
  // error-free stores write their enabled lanes.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && req_write && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  // FSM, clear counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt    <= '0;
      req_ready  <= 1'b0;
      init_busy  <= CLEAR_ON_RESET;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + IDX_W'(1);
          if (clr_cnt == LAST_IDX) begin
            state     <= ST_READY;
            req_ready <= 1'b1;
            init_busy <= 1'b0;
          end
        end
        ST_READY: begin
          req_ready <= 1'b1;
          init_busy <= 1'b0;
          if (accept) begin
            resp_valid <= 1'b1;
            resp_err   <= req_err;
            resp_rdata <= (req_err || req_write) ? '0 : ld_data;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed + randomised bench for data_ram (DEPTH_WORDS = 8).
// Expected responses are queued when a request is driven and compared when
// resp_valid is seen, including the cycle in which it must appear.
module tb_data_ram;

  localparam int DEPTH = 8;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_write, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_err, init_busy;
  logic [31:0]   resp_rdata;

  data_ram #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .init_busy  (init_busy)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: {due cycle[15:0], err, rdata[31:0]}
  logic [48:0] exp_q[$];
  logic [48:0] exp_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver: holds the request across one posedge; queues the expected response.
  task automatic send(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic e_err, input logic [31:0] e_rd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    exp_q.push_back({16'(cyc + 1), e_err, e_rd});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
  endtask

  task automatic release_and_sweep(input string tag);
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, "_ready_low"}, 32'(req_ready), 32'd0);
    n = 0;
    while (init_busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_cycles"}, 32'(n), 32'(DEPTH));
    check({tag, "_ready_high"}, 32'(req_ready), 32'd1);
  endtask

  // Monitor: compare responses on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("resp_cycle", 32'(cyc), 32'(exp_e[48:33]));
          check("resp_err", 32'(resp_err), 32'(exp_e[32]));
          check("resp_rdata", resp_rdata, exp_e[31:0]);
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][48:33]) <= cyc) begin
        exp_e = exp_q.pop_front();
        check("missing_resp", 32'(resp_valid), 32'd1);
      end
    end
  end

  logic [31:0] w, sh, ex;
  int          idx, off, sz, sg;

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_init_busy", 32'(init_busy), 32'd1);
    release_and_sweep("sweep");

    // Cleared memory, word loads / stores, byte and half lanes
    send(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 1'b0, 32'h0);
    send(1'b1, 2'b10, 1'b0, 32'h04, 32'h11223344, 1'b0, 32'h0);
    send(1'b0, 2'b00, 1'b0, 32'h04, 32'h0, 1'b0, 32'h44);
    send(1'b0, 2'b00, 1'b0, 32'h05, 32'h0, 1'b0, 32'h33);
    send(1'b0, 2'b00, 1'b0, 32'h06, 32'h0, 1'b0, 32'h22);
    send(1'b0, 2'b00, 1'b0, 32'h07, 32'h0, 1'b0, 32'h11);
    send(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, 1'b0, 32'h1122);
    send(1'b0, 2'b01, 1'b1, 32'h04, 32'h0, 1'b0, 32'h3344);
    send(1'b0, 2'b10, 1'b1, 32'h04, 32'h0, 1'b0, 32'h11223344);

    // Byte store and extension
    send(1'b1, 2'b00, 1'b0, 32'h09, 32'hABCDEFF0, 1'b0, 32'h0);
    send(1'b0, 2'b00, 1'b1, 32'h09, 32'h0, 1'b0, 32'hFFFFFFF0);
    send(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, 1'b0, 32'h000000F0);
    send(1'b0, 2'b00, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0);
    send(1'b0, 2'b00, 1'b0, 32'h0A, 32'h0, 1'b0, 32'h0);
    send(1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 1'b0, 32'h0);
    send(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0000F000);

    // Half store to upper lanes, signed half load
    send(1'b1, 2'b01, 1'b0, 32'h1A, 32'h00008001, 1'b0, 32'h0);
    send(1'b0, 2'b01, 1'b1, 32'h1A, 32'h0, 1'b0, 32'hFFFF8001);
    send(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 1'b0, 32'h80010000);

    // Errors
    send(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 1'b1, 32'h0);
    send(1'b1, 2'b10, 1'b0, 32'h02, 32'hFFFFFFFF, 1'b1, 32'h0);
    send(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0);
    send(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0);
    send(1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h0, 1'b1, 32'h0);
    send(1'b1, 2'b00, 1'b0, 32'h100, 32'h55, 1'b1, 32'h0);
    send(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0);

    // Back-to-back store then load
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    // Randomised words, then random byte/half loads against a model
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      model[i] = w;
      send(1'b1, 2'b10, 1'b0, 32'(4 * i), w, 1'b0, 32'h0);
    end
    for (int j = 0; j < 24; j++) begin
      idx = $urandom_range(DEPTH - 1, 0);
      sz  = $urandom_range(1, 0);
      off = (sz == 0) ? $urandom_range(3, 0) : 2 * $urandom_range(1, 0);
      sg  = $urandom_range(1, 0);
      sh  = model[idx] >> (8 * off);
      if (sz == 0) ex = (sg != 0 && sh[7])  ? (32'hFFFFFF00 | (sh & 32'hFF))   : (sh & 32'hFF);
      else         ex = (sg != 0 && sh[15]) ? (32'hFFFF0000 | (sh & 32'hFFFF)) : (sh & 32'hFFFF);
      send(1'b0, 2'(sz), sg[0], 32'(4 * idx + off), 32'h0, 1'b0, ex);
    end

    // Reset with a response pending
    send(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, model[3]);
    rst_n = 1'b0;
    #1;
    check("rst_drop_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(init_busy), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    release_and_sweep("resweep");
    send(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h0);
    send(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0);
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
Parametrised, byte-addressed, little-endian data memory for the MIPS core's load/store path. Supports byte, halfword and word accesses with per-byte write enables and sign- or zero-extension on loads. Uses a valid/ready request interface and a registered one-cycle response. Clears its storage after reset and flags misaligned, out-of-range and reserved-size accesses as errors.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two, at least 4.
ADDR_WIDTH, 32, width of req_addr.
CLEAR_ON_RESET, 1, 1 = sweep all words to 0 after reset; 0 = skip the sweep (storage contents undefined).

Ports:
clk  in  1  clock; everything sampled on posedge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
resp_valid  out  1  one-cycle pulse, response present.
resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
resp_err  out  1  qualified by resp_valid; 1 = access rejected.
init_busy  out  1  1 while the clear sweep runs.

Behaviour:
- Reset (rst_n low, asynchronous): state=CLEAR (or READY if CLEAR_ON_RESET=0); req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_busy=CLEAR_ON_RESET; clear counter=0.
- FSM states: CLEAR, READY.
  - CLEAR: one word per cycle is written to 0 at the counter value. The counter increments each cycle. After word DEPTH_WORDS-1 is written, the next state is READY. The sweep takes exactly DEPTH_WORDS cycles after reset deasserts. req_ready=0 and init_busy=1 throughout.
  - READY: req_ready=1 and init_busy=0. READY is never left except through reset.
- Request acceptance: a request is accepted when req_valid and req_ready are both 1 at a posedge. Inputs are don't-care otherwise. At most one request is accepted per cycle.
- Latency: the response appears in the cycle after acceptance (resp_valid=1 for exactly one cycle). Back-to-back requests give back-to-back responses. There is no response backpressure.
- Error conditions, checked in priority order: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr >= 4*DEPTH_WORDS.
  - On error: storage is unchanged, resp_err=1, resp_rdata=0.
- Store: write enables come from addr[1:0] and size.
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
  - The write commits at the acceptance edge. resp_rdata=0.
- Load: the addressed word is read at the acceptance edge. Lane(s) are selected by addr[1:0], then sign-extended if req_signed, else zero-extended. req_signed is ignored for word loads.
- Ordering: a load accepted the cycle after a store to the same address returns the stored data. A single request never both reads and writes.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are used only for the range check; there is no wrap-around aliasing.
- Reset during CLEAR or mid-traffic: any pending response is dropped, the FSM restarts in CLEAR and the sweep restarts from word 0.
- resp_rdata and resp_err hold their values when resp_valid=0; they are meaningful only with resp_valid=1.

Decomposition:
- Package data_ram_pkg holds:
  - access_size_t enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD);
  - ram_state_t enum (ST_CLEAR, ST_READY);
  - a function returning the 4-bit byte-enable mask for a given size and offset.
- One combinational sub-module, ram_lane_align:
  - inputs: size, offset, signed flag, raw 32-bit word, store data;
  - outputs: byte enables, the lane-shifted store word and the extended load value.
- The top level holds the storage array, the FSM/clear counter, the error check and the response registers.

Test Plan:
- Reset, DEPTH_WORDS=8: rst_n released → init_busy=1 and req_ready=0 for exactly 8 cycles, then req_ready=1; a word load from addr 0x1C → rdata 0x00000000, err=0.
- Store word 0x11223344 at 0x4; load bytes 0x4..0x7 unsigned → 0x44, 0x33, 0x22, 0x11; load half at 0x6 → 0x1122.
- Store byte 0xF0 at 0x9; load byte at 0x9 signed → 0xFFFFFFF0, unsigned → 0x000000F0; bytes 0x8, 0xA, 0xB of that word remain 0.
- Half load at 0x3 → err=1, rdata=0; word store at 0x2 → err=1 and a follow-up word load at 0x0 shows memory unchanged; size=11 → err=1; word load at 4*DEPTH_WORDS → err=1.
- Back-to-back: store word 0xDEADBEEF at 0x10, then the next cycle load word at 0x10 → resp_valid on consecutive cycles, second rdata=0xDEADBEEF.
- Assert rst_n low during traffic with a response pending → resp_valid=0 immediately, sweep restarts, and a previously written location reads 0 after init_busy falls.
